// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle 32-bit signed/unsigned restoring divider for EX.
// Ports: clk, rst (sync high), signed_div_i, opdata1_i, opdata2_i, start_i,
//   annul_i in; result_o {rem,quo}, ready_o (registered), stallreq_o out.
module ex_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BY_ZERO,
    S_ON,
    S_END
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W:0]   work;
  logic [DATA_W-1:0]   divisor;
  logic                sgn;
  logic                neg1;
  logic                neg2;

  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo_f;
  logic [DATA_W-1:0]   rem_f;

  always_comb begin
    mag1 = opdata1_i;
    mag2 = opdata2_i;
    if (signed_div_i && opdata1_i[DATA_W-1])
      mag1 = -opdata1_i;
    if (signed_div_i && opdata2_i[DATA_W-1])
      mag2 = -opdata2_i;
  end

  // Partial remainder lives in work[2W:W]; a 33-bit difference is enough,
  // since the remainder is always below twice the divisor, so bit W is
  // the borrow.
  assign diff = work[2*DATA_W:DATA_W] - {1'b0, divisor};

  assign quo = work[DATA_W-1:0];
  assign rem = work[2*DATA_W:DATA_W+1];

  always_comb begin
    quo_f = quo;
    rem_f = rem;
    if (sgn && (neg1 ^ neg2))
      quo_f = -quo;
    if (sgn && neg1)
      rem_f = -rem;
  end

  assign stallreq_o = start_i & ~ready_o & ~annul_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= S_BY_ZERO;
            end else begin
              state   <= S_ON;
              sgn     <= signed_div_i;
              neg1    <= opdata1_i[DATA_W-1];
              neg2    <= opdata2_i[DATA_W-1];
              divisor <= mag2;
              work    <= {{DATA_W{1'b0}}, mag1, 1'b0};
              cnt     <= '0;
            end
          end
        end
        S_BY_ZERO: begin
          state    <= S_END;
          ready_o  <= 1'b1;
          result_o <= '0;
        end
        S_ON: begin
          if (annul_i) begin
            state    <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt != CNT_W'(DATA_W)) begin
            if (diff[DATA_W])
              work <= {work[2*DATA_W-1:0], 1'b0};
            else
              work <= {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
            cnt <= cnt + 1'b1;
          end else begin
            state    <= S_END;
            ready_o  <= 1'b1;
            result_o <= {rem_f, quo_f};
          end
        end
        S_END: begin
          if (!start_i || annul_i) begin
            state    <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed checks of ex_div_unit results, latency and stall.
// Inputs driven on negedge, outputs sampled #1 after posedge.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  ex_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a division on a negedge, wait for ready, check result,
  // latency (edges from start to ready) and number of stalled cycles,
  // then drop start and check that the result is withdrawn.
  task automatic run_div(input string tag, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input int exp_lat);
    int cyc;
    int stalls;
    cyc = 0;
    stalls = 0;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    #1;
    if (stallreq_o) stalls++;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready_o || cyc >= 100) break;
      if (stallreq_o) stalls++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_res"}, result_o, exp_res);
    chk({tag, "_stalls"}, 64'(stalls), 64'(exp_lat));
    chk({tag, "_stall_rel"}, 64'(stallreq_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
    chk({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(ready_o), 64'd0);
    chk("rst_res", result_o, 64'd0);
    chk("rst_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("u100_7", 1'b0, 32'd100, 32'd7,
            64'h00000002_0000000E, 34);
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
            64'hFFFFFFFF_FFFFFFFD, 34);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
            64'h00000001_FFFFFFFD, 34);
    run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
            64'hFFFFFFFE_0000000E, 34);
    run_div("u_big_div", 1'b0, 32'hFFFFFFFF, 32'h80000001,
            64'h7FFFFFFE_00000001, 34);
    run_div("div0", 1'b0, 32'd1234, 32'd0,
            64'h0, 2);
    run_div("ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
            64'h00000000_80000000, 34);

    // Annul at iteration 10.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("annul_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("annul_rdy", 64'(ready_o), 64'd0);
    chk("annul_res", result_o, 64'd0);
    chk("annul_stall2", 64'(stallreq_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("annul_rdy_late", 64'(ready_o), 64'd0);
    run_div("post_annul", 1'b0, 32'hFFFFFFFF, 32'd1,
            64'h00000000_FFFFFFFF, 34);

    // Reset at iteration 20.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_rdy", 64'(ready_o), 64'd0);
    chk("mid_rst_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_div("post_rst", 1'b0, 32'd100, 32'd7,
            64'h00000002_0000000E, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
Multi-cycle 32-bit signed/unsigned divider for the EX stage. It consumes operands that the ID/EX pipeline register delivers for DIV/DIVU and returns {remainder, quotient} for HI/LO. While a division is in flight it raises a stall request to the pipeline controller. The controller turns that request into the stall vector that holds the IF–EX registers and bubbles EX→MEM.

Parameters:
DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
CNT_W, 6, width of the iteration counter; must hold the value DATA_W.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
signed_div_i  in  1  1 = signed DIV, 0 = unsigned DIVU; sampled at start
opdata1_i  in  DATA_W  dividend; sampled at start
opdata2_i  in  DATA_W  divisor; sampled at start
start_i  in  1  division request; held high by EX until the result is consumed
annul_i  in  1  abort the in-flight division (branch/exception flush)
result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}
ready_o  out  1  result valid
stallreq_o  out  1  stall request to the pipeline controller

Behaviour:
Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.
- All state, result_o and ready_o are registered; stallreq_o is combinational.

Reset (rst=1 at a clk edge, including mid-division):
- state=FREE, counter=0, result_o=0, ready_o=0.
- Any in-flight operation is discarded.

States: FREE, BY_ZERO, ON, END.

FREE:
- If start_i=1, annul_i=0 and opdata2_i==0: go to BY_ZERO.
- If start_i=1, annul_i=0 and opdata2_i!=0: go to ON.
  - Latch signed_div_i.
  - Latch |opdata1_i| and |opdata2_i| (magnitudes when signed, raw values when unsigned).
  - Latch the sign bits.
  - Load the 65-bit working register with {32'b0, dividend, 1'b0}; counter=0.
- Otherwise stay in FREE; ready_o=0, result_o=0.

BY_ZERO:
- Unconditionally go to END; the working result is 0.

ON (one restoring-division step per cycle):
- annul_i=1: go to FREE, ready_o=0, result_o=0; no result is produced.
- Else, if counter!=DATA_W:
  - Compute diff = upper33 - {1'b0, divisor}.
  - If diff is negative: shift left, inserting 0.
  - Else: replace upper with diff, then shift left, inserting 1.
  - counter+1.
- Else (counter==DATA_W), go to END and apply sign correction:
  - Quotient is negated when signed and sign(op1)!=sign(op2).
  - Remainder is negated when signed and op1 was negative.
  - Register both.

END:
- ready_o=1 and result_o=final value, held while start_i=1.
- When start_i=0: go to FREE, ready_o=0, result_o=0.
- annul_i in END behaves like start_i=0.

Timing and stall:
- Latency: start sampled at edge E0 (FREE→ON). There are 32 ON iterations, then ON→END. ready_o is first high after edge E0+33, i.e. 34 cycles from start.
- Divide-by-zero: ready_o is high after edge E0+1, with result 0.
- stallreq_o = start_i & ~ready_o & ~annul_i. It is therefore low on the first cycle ready_o is high, which lets EX advance.

Arithmetic:
- Two's-complement negation is modulo 2^32.
- 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0. This overflow case is not trapped.

Simultaneous events:
- rst beats everything; annul_i beats start_i.
- start_i dropping while in ON (not legal from EX) is ignored; the division completes into END, then END→FREE on the next cycle.

Test Plan:
- Unsigned 100/7: start_i=1, signed=0, op1=100, op2=7.
  - stallreq_o=1 for 34 cycles, then ready_o=1.
  - result_o=0x00000002_0000000E.
  - Drop start_i → ready_o=0 next cycle.
- Signed -7/2: op1=0xFFFFFFF9, op2=2.
  - quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - Also 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: op2=0, start_i=1.
  - ready_o=1 two cycles after start, result_o=0.
- Annul at iteration 10: annul_i pulsed for one cycle.
  - Next cycle state=FREE, ready_o stays 0, stallreq_o=0.
  - A new start 0xFFFFFFFF/1 (unsigned) then completes with quotient 0xFFFFFFFF, remainder 0.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → result_o=0x00000000_80000000.
- Reset mid-division: rst=1 at iteration 20.
  - Next cycle ready_o=0, result_o=0.
  - A subsequent 100/7 yields the same result and latency as the first test.
